seg7_595_scan: RTL and testbench

Multiplexed 8-digit seven-segment scanner that drives the board's cascaded 74HC595 pair through `seg7_SH_CP`, `seg7_ST_CP` and `seg7_DS`. It replaces the tied-off display pins at the top level.

- Accepts a 32-bit hex value plus per-digit decimal-point and enable masks over a valid/ready handshake.
- Continuously refreshes the display one digit at a time.
- Serialises one 16-bit frame per digit: segment byte first, then the digit-select byte.

---
 rtl/seg7_595_scan.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_595_scan.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_595_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_595_scan
// Purpose  : 8-digit multiplexed seven-segment scanner driving a cascaded
//            74HC595 pair (segment byte first, then digit-select byte).
//            Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0  initial release
// ============================================================================
module seg7_595_scan #(
    parameter int CLK_DIV     = 4,
    parameter int HOLD_CYCLES = 25000
) (
    input  logic        clk_25M,
    input  logic        SYS_RSTN,
    input  logic        disp_valid,
    output logic        disp_ready,
    input  logic [31:0] disp_value,
    input  logic [7:0]  disp_dp,
    input  logic [7:0]  disp_en,
    output logic        seg7_SH_CP,
    output logic        seg7_ST_CP,
    output logic        seg7_DS,
    output logic        frame_done
);

    localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_LATCH = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          r_digit;
    logic [31:0]         r_pend_value;
    logic [7:0]          r_pend_dp;
    logic [7:0]          r_pend_en;
    logic [31:0]         r_act_value;
    logic [7:0]          r_act_dp;
    logic [7:0]          r_act_en;
    logic [14:0]         r_frame;
    logic [3:0]          r_bit_cnt;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_sh_cp;
    logic                r_st_cp;
    logic                r_ds;
    logic                r_frame_done;

    logic        w_load_copy;
    logic        w_accept;
    logic [31:0] w_src_value;
    logic [7:0]  w_src_dp;
    logic [7:0]  w_src_en;
    logic [3:0]  w_nibble;
    logic        w_blank;
    logic [7:0]  w_seg;
    logic [7:0]  w_sel;
    logic [15:0] w_frame;

    function automatic logic [7:0] f_seg7(input logic [3:0] nib);
        case (nib)
            4'h0: f_seg7 = 8'hC0;
            4'h1: f_seg7 = 8'hF9;
            4'h2: f_seg7 = 8'hA4;
            4'h3: f_seg7 = 8'hB0;
            4'h4: f_seg7 = 8'h99;
            4'h5: f_seg7 = 8'h92;
            4'h6: f_seg7 = 8'h82;
            4'h7: f_seg7 = 8'hF8;
            4'h8: f_seg7 = 8'h80;
            4'h9: f_seg7 = 8'h90;
            4'hA: f_seg7 = 8'h88;
            4'hB: f_seg7 = 8'h83;
            4'hC: f_seg7 = 8'hC6;
            4'hD: f_seg7 = 8'hA1;
            4'hE: f_seg7 = 8'h86;
            default: f_seg7 = 8'h8E;
        endcase
    endfunction

    // Digit 0's LOAD is the only point where pending becomes active, so the
    // frame built in that cycle must already see the incoming data.
    assign w_load_copy = (r_state == c_ST_LOAD) && (r_digit == 3'd0);
    assign disp_ready  = !w_load_copy;
    assign w_accept    = disp_valid && !w_load_copy;

    assign w_src_value = w_load_copy ? r_pend_value : r_act_value;
    assign w_src_dp    = w_load_copy ? r_pend_dp    : r_act_dp;
    assign w_src_en    = w_load_copy ? r_pend_en    : r_act_en;
    assign w_nibble    = w_src_value[{r_digit, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_upper_zero;
    assign w_upper_zero = (w_src_value >> {r_digit, 2'b00}) == 32'd0;
    assign w_blank      = (r_digit != 3'd0) && w_upper_zero && !w_src_dp[r_digit];
`else
    assign w_blank      = 1'b0;
`endif

    always_comb begin
        w_seg = 8'hFF;
        if (w_src_en[r_digit] && !w_blank) begin
            w_seg = f_seg7(w_nibble);
            if (w_src_dp[r_digit]) begin
                w_seg[7] = 1'b0;
            end
        end
    end

    assign w_sel   = ~(8'd1 << r_digit);
    assign w_frame = {w_seg, w_sel};

    always_ff @(posedge clk_25M or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            r_state      <= c_ST_IDLE;
            r_digit      <= 3'd0;
            r_pend_value <= 32'd0;
            r_pend_dp    <= 8'd0;
            r_pend_en    <= 8'd0;
            r_act_value  <= 32'd0;
            r_act_dp     <= 8'd0;
            r_act_en     <= 8'd0;
            r_frame      <= 15'd0;
            r_bit_cnt    <= 4'd0;
            r_div_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_sh_cp      <= 1'b0;
            r_st_cp      <= 1'b0;
            r_ds         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_pend_value <= disp_value;
                r_pend_dp    <= disp_dp;
                r_pend_en    <= disp_en;
            end
            case (r_state)
                c_ST_IDLE: r_state <= c_ST_LOAD;
                c_ST_LOAD: begin
                    if (w_load_copy) begin
                        r_act_value <= r_pend_value;
                        r_act_dp    <= r_pend_dp;
                        r_act_en    <= r_pend_en;
                    end
                    r_ds      <= w_frame[15];
                    r_frame   <= w_frame[14:0];
                    r_bit_cnt <= 4'd15;
                    r_div_cnt <= '0;
                    r_sh_cp   <= 1'b0;
                    r_state   <= c_ST_SHIFT;
                end
                c_ST_SHIFT: begin
                    if (r_div_cnt == c_DIV_LAST) begin
                        r_div_cnt <= '0;
                        if (!r_sh_cp) begin
                            r_sh_cp <= 1'b1;
                        end else begin
                            r_sh_cp <= 1'b0;
                            if (r_bit_cnt == 4'd0) begin
                                r_st_cp <= 1'b1;
                                r_state <= c_ST_LATCH;
                            end else begin
                                // Next bit is presented as SH_CP falls.
                                r_bit_cnt <= r_bit_cnt - 4'd1;
                                r_ds      <= r_frame[14];
                                r_frame   <= {r_frame[13:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                c_ST_LATCH: begin
                    if (r_div_cnt == c_DIV_LAST) begin
                        r_div_cnt    <= '0;
                        r_st_cp      <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_hold_cnt   <= '0;
                        r_state      <= c_ST_HOLD;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_digit <= r_digit + 3'd1;
                        r_state <= c_ST_LOAD;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign seg7_SH_CP = r_sh_cp;
    assign seg7_ST_CP = r_st_cp;
    assign seg7_DS    = r_ds;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_595_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_595_scan
// Purpose  : Scoreboard bench for seg7_595_scan; expected frames are queued by
//            the stimulus and popped by a monitor at every ST_CP latch.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_595_scan;

    localparam int c_CLK_DIV = 1;
    localparam int c_HOLD    = 4;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] c_PAD = 8'hFF;
`else
    localparam logic [7:0] c_PAD = 8'hC0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [31:0] disp_value = 32'd0;
    logic [7:0]  disp_dp = 8'd0;
    logic [7:0]  disp_en = 8'd0;
    logic        seg7_SH_CP;
    logic        seg7_ST_CP;
    logic        seg7_DS;
    logic        frame_done;

    seg7_595_scan #(
        .CLK_DIV     (c_CLK_DIV),
        .HOLD_CYCLES (c_HOLD)
    ) u_dut (
        .clk_25M    (clk),
        .SYS_RSTN   (rst_n),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_value (disp_value),
        .disp_dp    (disp_dp),
        .disp_en    (disp_en),
        .seg7_SH_CP (seg7_SH_CP),
        .seg7_ST_CP (seg7_ST_CP),
        .seg7_DS    (seg7_DS),
        .frame_done (frame_done)
    );

    always #20 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];

    int          mon_bits = 0;
    int          n_latched = 0;
    int          frames_since_reset = 0;
    int          low_run = 0;
    int          st_width = 0;
    logic [15:0] sr = 16'd0;
    logic        prev_sh = 1'b0;
    logic        prev_st = 1'b0;
    logic        prev_ds = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] seg, input int k);
        logic [7:0] sel;
        sel = 8'd1 << k;
        exp_q.push_back({seg, ~sel});
    endtask

    // Monitor: rebuild frames from SH_CP rising edges, compare at each latch.
    always @(negedge clk) begin
        logic st_fell;
        logic [15:0] exp;
        if (!rst_n) begin
            mon_bits           = 0;
            frames_since_reset = 0;
            low_run            = 0;
            st_width           = 0;
        end else begin
            if (seg7_SH_CP && !prev_sh) begin
                sr = {sr[14:0], seg7_DS};
                mon_bits++;
            end
            if (seg7_DS != prev_ds)
                check("ds_changes_only_while_sh_low", {31'd0, seg7_SH_CP}, 32'd0);
            if (seg7_ST_CP && !prev_st) begin
                check("bits_per_frame", mon_bits, 16);
                if (exp_q.size() == 0) begin
                    check("unexpected_latch", {16'd0, sr}, 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("frame", {16'd0, sr}, {16'd0, exp});
                end
                n_latched++;
                frames_since_reset++;
                mon_bits = 0;
                st_width = 0;
            end
            if (seg7_ST_CP) st_width++;
            st_fell = prev_st && !seg7_ST_CP;
            if (st_fell)
                check("st_cp_width", st_width, c_CLK_DIV);
            if (st_fell || frame_done)
                check("frame_done_on_st_fall", {31'd0, frame_done}, {31'd0, st_fell});
            if (!disp_ready) begin
                if (low_run == 0)
                    check("copy_at_digit0", frames_since_reset % 8, 0);
                low_run++;
            end else if (low_run > 0) begin
                check("ready_low_width", low_run, 1);
                low_run = 0;
            end
        end
        prev_sh = seg7_SH_CP;
        prev_st = seg7_ST_CP;
        prev_ds = seg7_DS;
    end

    task automatic send(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            disp_valid = 1'b1;
            disp_value = v;
            disp_dp    = dp;
            disp_en    = en;
            acc        = disp_ready;
            @(posedge clk);
        end
        if (!acc) check("handshake_timeout", 32'd0, 32'd1);
        @(negedge clk);
        disp_valid = 1'b0;
    endtask

    task automatic wait_latched(input int target);
        for (int i = 0; i < 3000; i++) begin
            if (n_latched >= target) return;
            @(negedge clk);
            #1;
        end
        check("latch_timeout", n_latched, target);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {27'd0, seg7_SH_CP, seg7_ST_CP, seg7_DS, frame_done, disp_ready}, 32'h1);
    endtask

    initial begin
        logic found;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");

        // Scan 1 blank, scan 2 shows 0xA8 (dp on digit 0), scan 3 all '2'.
        for (int k = 0; k < 8; k++) push_frame(8'hFF, k);
        push_frame(8'h00, 0);
        push_frame(8'h88, 1);
        for (int k = 2; k < 8; k++) push_frame(c_PAD, k);
        for (int k = 0; k < 8; k++) push_frame(8'hA4, k);

        #1 rst_n = 1'b1;

        wait_latched(1);
        send(32'h0000_00A8, 8'h01, 8'hFF);

        wait_latched(11);
        send(32'h1111_1111, 8'h00, 8'hFF);
        send(32'h2222_2222, 8'h00, 8'hFF);

        // Abort the first frame of scan 4 after 7 shifted bits.
        wait_latched(24);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mon_bits == 7) found = 1'b1;
        end
        check("reached_bit7", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_outputs");
        repeat (4) @(negedge clk);
        check_reset_outputs("held_reset_outputs");

        for (int k = 0; k < 8; k++) push_frame(8'hFF, k);
        push_frame(8'hFF, 0);
        #1 rst_n = 1'b1;

        wait_latched(33);
        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(40 * 20000);
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
